// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {StIdle = 1'b0, StWait = 1'b1} arb_state_e;

    typedef enum logic {OwnIf = 1'b0, OwnDm = 1'b1} owner_e;

    localparam logic [3:0]  WenRead    = 4'b0000;
    localparam int unsigned StarveCntW = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch/data winner select with the fetch starvation counter.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned StarveMax = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_req_i,
    input  logic   if_elig_i,
    input  logic   dm_req_i,
    input  logic   if_gnt_i,
    input  logic   dm_gnt_i,
    output owner_e winner_o
);

    localparam logic [StarveCntW-1:0] CntMax = StarveCntW'(StarveMax);

    logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;

    // Data port wins by default; a fetch that has lost StarveMax times in a row is forced through.
    always_comb begin
        winner_o = OwnDm;
        if (if_elig_i && (!dm_req_i || starve_cnt_q == CntMax)) begin
            winner_o = OwnIf;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt_i) begin
            starve_cnt_d = '0;
        end else if (dm_gnt_i && if_req_i && starve_cnt_q < CntMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports,
// one transaction outstanding, with response routing and fetch-kill on flush.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                flush_i,
    input  logic                dm_req_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W/8-1:0] dm_w_en_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_w_en_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int unsigned BeW = DATA_W / 8;

    arb_state_e state_q;
    owner_e     owner_q;
    logic       drop_q;
    owner_e     winner;
    logic       if_elig, req_any, arb_on, fire, rsp;

    assign if_elig = if_req_i & ~flush_i;
    assign req_any = dm_req_i | if_elig;
    // rst_n gating keeps every output low while reset is held.
    assign arb_on  = rst_n & (state_q == StIdle) & req_any;
    assign fire    = arb_on & mem_ready_i;
    assign rsp     = rst_n & (state_q == StWait) & mem_rvalid_i;

    mem_arb_pick #(
        .StarveMax (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req_i  (if_req_i),
        .if_elig_i (if_elig),
        .dm_req_i  (dm_req_i),
        .if_gnt_i  (if_gnt_o),
        .dm_gnt_i  (dm_gnt_o),
        .winner_o  (winner)
    );

    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_w_en_o  = BeW'(WenRead);
        mem_wdata_o = '0;
        if (arb_on) begin
            mem_req_o = 1'b1;
            if (winner == OwnDm) begin
                mem_addr_o  = dm_addr_i;
                mem_w_en_o  = dm_w_en_i;
                mem_wdata_o = dm_wdata_i;
            end else begin
                mem_addr_o = if_addr_i;
            end
        end
    end

    assign if_gnt_o    = fire & (winner == OwnIf);
    assign dm_gnt_o    = fire & (winner == OwnDm);
    // A fetch response is dropped if a flush hit during WAIT or lands with it.
    assign if_rvalid_o = rsp & (owner_q == OwnIf) & ~drop_q & ~flush_i;
    assign dm_rvalid_o = rsp & (owner_q == OwnDm);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    assign busy_o      = (state_q == StWait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= OwnIf;
            drop_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fire) begin
                        state_q <= StWait;
                        owner_q <= winner;
                        drop_q  <= 1'b0;
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        state_q <= StIdle;
                        drop_q  <= 1'b0;
                    end else if (flush_i && owner_q == OwnIf) begin
                        drop_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle behavioural model plus literal checkpoints.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        flush = 1'b0;
    logic        dm_req = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [3:0]  dm_w_en = 4'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_w_en;

    logic        inject = 1'b0;
    logic        rv_injected = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    bit          m_busy = 1'b0, m_own_dm = 1'b0, m_drop = 1'b0;
    int          m_starve = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .flush_i      (flush),
        .dm_req_i     (dm_req),
        .dm_addr_i    (dm_addr),
        .dm_w_en_i    (dm_w_en),
        .dm_wdata_i   (dm_wdata),
        .dm_gnt_o     (dm_gnt),
        .dm_rvalid_o  (dm_rvalid),
        .dm_rdata_o   (dm_rdata),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_w_en_o   (mem_w_en),
        .mem_wdata_o  (mem_wdata),
        .mem_ready_i  (mem_ready),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                tick();
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle: busy still 1 after 20 cycles, required 0");
        tick();
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00500093 : (a ^ 32'h5A5A0000);
    endfunction

    // Memory model: accepts on mem_req & mem_ready, answers two cycles later; reset clears it.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            rsp_cnt = 0;
        end else if (mem_req && mem_ready) begin
            rsp_cnt  = 2;
            rsp_data = mem_val(mem_addr);
        end
        @(posedge clk);
        #1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        rv_injected = 1'b0;
        if (!rst_n) begin
            rsp_cnt = 0;
        end else if (rsp_cnt == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_data;
            rsp_cnt    = 0;
        end else if (rsp_cnt > 1) begin
            rsp_cnt--;
        end else if (inject) begin
            mem_rvalid  = 1'b1;
            mem_rdata   = 32'hBAD0BAD0;
            rv_injected = 1'b1;
        end
    end

    always @(negedge clk) begin : model_cmp
        logic        e_ig, e_dg, e_ir, e_dr, e_mr, e_bz;
        logic [31:0] e_ird, e_drd, e_ma, e_mwd;
        logic [3:0]  e_mwe;
        bit          if_ok, any_req, if_wins;
        e_ig = 1'b0; e_dg = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_mr = 1'b0; e_bz = 1'b0;
        e_ird = 32'h0; e_drd = 32'h0; e_ma = 32'h0; e_mwd = 32'h0; e_mwe = 4'h0;
        if (!rst_n) begin
            m_busy = 1'b0; m_own_dm = 1'b0; m_drop = 1'b0; m_starve = 0;
        end else if (!m_busy) begin
            if_ok   = if_req && !flush;
            any_req = dm_req || if_ok;
            if_wins = if_ok && (!dm_req || m_starve == SMAX);
            if (mem_rvalid && !rv_injected) begin
                n_cmp++;
                n_bad++;
                $display("FAIL proto_idle_rvalid: got mem_rvalid=1 while idle, required 0");
            end
            if (any_req) begin
                e_mr  = 1'b1;
                e_ma  = if_wins ? if_addr : dm_addr;
                e_mwe = if_wins ? 4'h0 : dm_w_en;
                e_mwd = if_wins ? 32'h0 : dm_wdata;
                if (mem_ready) begin
                    e_ig = if_wins;
                    e_dg = !if_wins;
                    if (if_wins) m_starve = 0;
                    else if (if_req && m_starve < SMAX) m_starve++;
                    m_busy   = 1'b1;
                    m_own_dm = !if_wins;
                    m_drop   = 1'b0;
                end
            end
        end else begin
            e_bz = 1'b1;
            if (mem_rvalid) begin
                if (m_own_dm) begin
                    e_dr  = 1'b1;
                    e_drd = mem_rdata;
                end else if (!m_drop && !flush) begin
                    e_ir  = 1'b1;
                    e_ird = mem_rdata;
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (flush && !m_own_dm) begin
                m_drop = 1'b1;
            end
        end
        check1("m_if_gnt", if_gnt, e_ig);
        check1("m_dm_gnt", dm_gnt, e_dg);
        check1("m_if_rvalid", if_rvalid, e_ir);
        check32("m_if_rdata", if_rdata, e_ird);
        check1("m_dm_rvalid", dm_rvalid, e_dr);
        check32("m_dm_rdata", dm_rdata, e_drd);
        check1("m_mem_req", mem_req, e_mr);
        check32("m_mem_addr", mem_addr, e_ma);
        check32("m_mem_w_en", {28'h0, mem_w_en}, {28'h0, e_mwe});
        check32("m_mem_wdata", mem_wdata, e_mwd);
        check1("m_busy", busy, e_bz);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [5:0] seq;
        int         ng;
        dm_req  = 1'b1;
        dm_addr = 32'h1234;
        repeat (2) @(negedge clk);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_busy", busy, 1'b0);
        dm_req = 1'b0;
        tick();
        rst_n = 1'b1;

        // Lone fetch
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1;
        @(negedge clk);
        check1("t1_if_gnt_c0", if_gnt, 1'b1);
        check32("t1_mem_addr", mem_addr, 32'h40);
        check1("t1_busy_c0", busy, 1'b0);
        tick(); if_req = 1'b0;
        @(negedge clk);
        check1("t1_busy_c1", busy, 1'b1);
        check1("t1_if_rvalid_c1", if_rvalid, 1'b0);
        tick();
        @(negedge clk);
        check1("t1_if_rvalid_c2", if_rvalid, 1'b1);
        check32("t1_if_rdata_c2", if_rdata, 32'h00500093);
        check1("t1_busy_c2", busy, 1'b1);
        tick();
        @(negedge clk);
        check1("t1_busy_c3", busy, 1'b0);
        tick();

        // Simultaneous requests: data first, fetch right after the response
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_addr = 32'h1000; dm_w_en = 4'hF; dm_wdata = 32'hCAFEBABE;
        @(negedge clk);
        check1("t2_dm_gnt", dm_gnt, 1'b1);
        check1("t2_if_gnt_c0", if_gnt, 1'b0);
        check32("t2_mem_w_en", {28'h0, mem_w_en}, 32'hF);
        check32("t2_mem_wdata", mem_wdata, 32'hCAFEBABE);
        tick(); dm_req = 1'b0; dm_w_en = 4'h0;
        tick();
        @(negedge clk);
        check1("t2_dm_rvalid_c2", dm_rvalid, 1'b1);
        check1("t2_if_gnt_c2", if_gnt, 1'b0);
        tick();
        @(negedge clk);
        check1("t2_if_gnt_c3", if_gnt, 1'b1);
        check32("t2_mem_addr_c3", mem_addr, 32'h44);
        tick(); if_req = 1'b0;
        wait_idle();

        // Starvation: expect D D D D I D
        seq = 6'h0; ng = 0;
        if_req = 1'b1; if_addr = 32'h48;
        dm_req = 1'b1; dm_addr = 32'h2000; dm_w_en = 4'h0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if (if_gnt || dm_gnt) begin
                seq[ng] = if_gnt;
                ng++;
            end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        check32("t3_grant_count", ng, 32'd6);
        check32("t3_grant_seq", {26'h0, seq}, 32'h10);
        wait_idle();

        // Flush during fetch WAIT, queued data request granted next
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        check1("t4_if_gnt", if_gnt, 1'b1);
        tick(); if_req = 1'b0; flush = 1'b1;
        dm_req = 1'b1; dm_addr = 32'h3000; dm_w_en = 4'h0;
        @(negedge clk);
        check1("t4_dm_gnt_wait", dm_gnt, 1'b0);
        check1("t4_busy_c1", busy, 1'b1);
        tick(); flush = 1'b0;
        @(negedge clk);
        check1("t4_if_rvalid_dropped", if_rvalid, 1'b0);
        check32("t4_if_rdata_dropped", if_rdata, 32'h0);
        check1("t4_busy_c2", busy, 1'b1);
        tick();
        @(negedge clk);
        check1("t4_busy_c3", busy, 1'b0);
        check1("t4_dm_gnt_c3", dm_gnt, 1'b1);
        tick(); dm_req = 1'b0;
        wait_idle();
        if_req = 1'b1; if_addr = 32'h84; flush = 1'b1;
        @(negedge clk);
        check1("t4_idle_flush_mem_req", mem_req, 1'b0);
        check1("t4_idle_flush_if_gnt", if_gnt, 1'b0);
        tick(); flush = 1'b0;
        @(negedge clk);
        check1("t4_refetch_gnt", if_gnt, 1'b1);
        tick(); if_req = 1'b0;
        tick(); flush = 1'b1;
        @(negedge clk);
        check1("t4_same_cycle_drop", if_rvalid, 1'b0);
        check1("t4_same_cycle_busy", busy, 1'b1);
        tick(); flush = 1'b0;
        wait_idle();

        // Backpressure on a byte store
        mem_ready = 1'b0;
        dm_req = 1'b1; dm_addr = 32'h1003; dm_w_en = 4'h1; dm_wdata = 32'hAB;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check1("t5_no_dm_gnt", dm_gnt, 1'b0);
            check1("t5_mem_req", mem_req, 1'b1);
            check32("t5_mem_addr_stable", mem_addr, 32'h1003);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check1("t5_dm_gnt", dm_gnt, 1'b1);
        check32("t5_mem_w_en", {28'h0, mem_w_en}, 32'h1);
        tick(); dm_req = 1'b0; dm_w_en = 4'h0;
        wait_idle();

        // Asynchronous reset in WAIT, then a stray response after release
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        check1("t6_if_gnt", if_gnt, 1'b1);
        tick(); if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h4000;
        #2;
        check1("t6_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("t6_rst_busy", busy, 1'b0);
        check1("t6_rst_mem_req", mem_req, 1'b0);
        check1("t6_rst_dm_gnt", dm_gnt, 1'b0);
        check32("t6_rst_mem_addr", mem_addr, 32'h0);
        tick(); dm_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check1("t6_late_if_rvalid", if_rvalid, 1'b0);
        check1("t6_late_dm_rvalid", dm_rvalid, 1'b0);
        check1("t6_late_busy", busy, 1'b0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
